masked_inv_sub_nibbles: RTL and testbench
=========================================

MASKED_INV_SUB_NIBBLES -- requirements
Module: masked_inv_sub_nibbles

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit nibbles per state; only 4 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to process one masked state; sampled only in IDLE.
REQ-005 SHALL have port A_in, input, 16, share A of the masked ciphertext state; nibble 0 = bits 15:12.
REQ-006 SHALL have port B_in, input, 16, share B of the masked state; true state = A_in ^ B_in.
REQ-007 SHALL have port Z, input, 12, fresh randomness for one nibble: six 2-bit DOM masks Z[1:0]..Z[11:10].
REQ-008 SHALL have port rnd_req, output, 1, high in each cycle in which Z is consumed.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when A_out/B_out are complete.
REQ-011 SHALL have port A_out, output, 16, share A of the result.
REQ-012 SHALL have port B_out, output, 16, share B of the result.

Function
REQ-013 SHALL compute, per nibble, A_out ^ B_out = InvS(A_in ^ B_in) using the S-AES inverse S-box: 0->A 1->5 2->9 3->B 4->1 5->7 6->8 7->F 8->6 9->0 A->2 B->3 C->C D->4 E->D F->E.
REQ-014 SHALL never combine shares A and B outside a DOM multiplier cross-domain term masked by Z; the inverse affine map is applied share-wise, with its constant added to share A only.
REQ-015 SHALL implement the nibble core as a 2-stage registered pipeline: inverse affine plus GF(2^2) tower transform, DOM multiply and square-scale (Z[3:0]) -> register -> GF(2^2) inversion plus two DOM multipliers (Z[11:4]) -> register -> inverse tower transform.
REQ-016 SHALL sample all 12 bits of Z in the cycle a nibble enters the core; Z[11:4] is delayed internally by one register to stage 2.
REQ-017 SHALL use FSM states IDLE, FEED, DRAIN, DONE.
REQ-018 IDLE: start=1 SHALL capture A_in/B_in into internal share registers and go to FEED; start=0 stays in IDLE.
REQ-019 FEED SHALL last exactly 4 cycles, presenting nibble k (k = 0..3, counter 2 bits) to the core in the k-th FEED cycle with rnd_req=1; after k=3 go to DRAIN.
REQ-020 DRAIN SHALL last 2 cycles while the pipeline empties; rnd_req=0; then go to DONE.
REQ-021 The result nibble k SHALL be written into A_out/B_out position k exactly 2 cycles after it entered the core; other positions hold.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE; done is therefore high exactly 7 cycles after the cycle in which start was accepted.
REQ-023 start while busy=1 (including the DONE cycle) SHALL be ignored with no effect on state, counter, or captured inputs.
REQ-024 A_out/B_out SHALL remain stable from done until the next accepted start; they are undefined-but-masked while busy.
REQ-025 A_in, B_in, and Z changes outside their sampling cycles SHALL have no effect on the result.

Reset
REQ-026 reset=1 SHALL, at the next clock edge and regardless of state, force IDLE, clear the nibble counter, and drive busy=0, done=0, rnd_req=0, A_out=0, B_out=0.
REQ-027 reset SHALL clear all pipeline and internal share registers to 0; reset asserted mid-FEED/DRAIN aborts the operation with no done pulse.
REQ-028 reset has priority over start in the same cycle.

Verification
REQ-029 SHALL cover: A_in=0x0000, B_in=0x0000, Z=0 -> done at +7 cycles, A_out^B_out=0xAAAA.
REQ-030 SHALL cover: A_in=0xE2C4, B_in=0xF0F0, Z random each cycle -> A_out^B_out=0x59B1, rnd_req high exactly 4 cycles.
REQ-031 SHALL cover: all 256 (A,B) nibble pairs in every position with random Z -> XOR matches the REQ-013 table; forward masked S-box of the result returns the original value, e.g. 0x59B1 -> 0x1234.
REQ-032 SHALL cover: start pulsed in the second FEED cycle and in the DONE cycle -> ignored; exactly one done and an unchanged result.
REQ-033 SHALL cover: reset in the second DRAIN cycle -> next cycle busy=0, outputs 0, no done; a new start then completes normally.
REQ-034 SHALL cover: back-to-back operations (start in the first IDLE cycle after DONE) -> the second done is 8 cycles after the first done, with correct results for both.

Source files
------------

// File: rtl/masked_inv_sub_nibbles.sv
// Two-share masked S-AES inverse SubNibbles: one nibble per cycle enters a 2-stage
// GF((2^2)^2) tower-field inversion core with DOM multipliers fed by fresh randomness Z.
module masked_inv_sub_nibbles #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A_in,
  input  logic [4*NIBBLES-1:0]   B_in,
  input  logic [11:0]            Z,
  output logic                   rnd_req,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   A_out,
  output logic [4*NIBBLES-1:0]   B_out
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  // GF(4) elements are {coef of w, const}, with w^2 = w + 1.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // Squaring is linear in GF(4) and doubles as inversion.
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // N * a^2 with tower constant N = w^2.
  function automatic logic [1:0] gf4_sq_scl(input logic [1:0] a);
    return {a[1] ^ a[0], a[0]};
  endfunction

  // Linear part of the inverse affine map; constant 4'hC is added on share A only.
  function automatic logic [3:0] inv_aff_lin(input logic [3:0] y);
    return {y[1] ^ y[2] ^ y[3], y[0] ^ y[1] ^ y[2],
            y[0] ^ y[1] ^ y[3], y[0] ^ y[2] ^ y[3]};
  endfunction

  // Polynomial basis (x^4+x+1) <-> tower {h1,h0,l1,l0}, with Y = x^2 and W = x^5.
  function automatic logic [3:0] to_tower(input logic [3:0] p);
    return {p[3], p[3] ^ p[2] ^ p[1], p[3] ^ p[1], p[3] ^ p[0]};
  endfunction

  function automatic logic [3:0] from_tower(input logic [3:0] t);
    return {t[3], t[2] ^ t[1], t[3] ^ t[1], t[3] ^ t[0]};
  endfunction

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        accept;
  logic [15:0] a_sh, b_sh;

  // Stage-0 combinational signals
  logic [3:0]  in_a, in_b, ta, tb;
  logic [1:0]  aha, ala, ahb, alb;

  // Stage-1 registers: inner and cross DOM terms are kept apart until the next stage.
  logic        s1_vld;
  logic [1:0]  s1_idx;
  logic [1:0]  s1_ha, s1_hb, s1_sa, s1_sb;
  logic [1:0]  s1_la, s1_lb, s1_xa, s1_xb;
  logic [7:0]  s1_z;

  // Stage-2 combinational signals
  logic [1:0]  da, db;

  // Stage-2 registers
  logic        s2_vld;
  logic [1:0]  s2_idx;
  logic [1:0]  s2_hia, s2_hxa, s2_hib, s2_hxb;
  logic [1:0]  s2_lia, s2_lxa, s2_lib, s2_lxb;

  logic [3:0]  res_a, res_b;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = FEED;
          cnt_nx   = '0;
        end
      end
      FEED: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) state_nx = DRAIN;
      end
      DRAIN: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd1) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rnd_req = (state == FEED);
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

  always_comb begin
    in_a = '0;
    in_b = '0;
    case (cnt)
      2'd0: begin in_a = a_sh[15:12]; in_b = b_sh[15:12]; end
      2'd1: begin in_a = a_sh[11:8];  in_b = b_sh[11:8];  end
      2'd2: begin in_a = a_sh[7:4];   in_b = b_sh[7:4];   end
      default: begin in_a = a_sh[3:0]; in_b = b_sh[3:0]; end
    endcase
    ta  = to_tower(inv_aff_lin(in_a) ^ 4'hC);
    tb  = to_tower(inv_aff_lin(in_b));
    aha = ta[3:2];
    ala = ta[1:0];
    ahb = tb[3:2];
    alb = tb[1:0];
  end

  // Norm delta = N*h^2 + l^2 + h*l; its GF(4) inverse is simply its square.
  always_comb begin
    da    = gf4_sq(s1_la ^ s1_xa);
    db    = gf4_sq(s1_lb ^ s1_xb);
    res_a = from_tower({s2_hia ^ s2_hxa, s2_lia ^ s2_lxa});
    res_b = from_tower({s2_hib ^ s2_hxb, s2_lib ^ s2_lxb});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        a_sh <= A_in;
        b_sh <= B_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
      s1_ha  <= '0;
      s1_hb  <= '0;
      s1_sa  <= '0;
      s1_sb  <= '0;
      s1_la  <= '0;
      s1_lb  <= '0;
      s1_xa  <= '0;
      s1_xb  <= '0;
      s1_z   <= '0;
    end else begin
      s1_vld <= (state == FEED);
      s1_idx <= cnt;
      s1_ha  <= aha ^ Z[3:2];
      s1_hb  <= ahb ^ Z[3:2];
      s1_sa  <= aha ^ ala;
      s1_sb  <= ahb ^ alb;
      s1_la  <= gf4_sq_scl(aha) ^ gf4_sq(ala) ^ gf4_mul(aha, ala);
      s1_lb  <= gf4_sq_scl(ahb) ^ gf4_sq(alb) ^ gf4_mul(ahb, alb);
      s1_xa  <= gf4_mul(aha, alb) ^ Z[1:0];
      s1_xb  <= gf4_mul(ahb, ala) ^ Z[1:0];
      s1_z   <= Z[11:4];
    end
  end

  // s1_z holds Z[11:4]: [1:0] and [3:2] mask the cross terms, [5:4] and [7:6] remask the inner terms.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld <= 1'b0;
      s2_idx <= '0;
      s2_hia <= '0;
      s2_hxa <= '0;
      s2_hib <= '0;
      s2_hxb <= '0;
      s2_lia <= '0;
      s2_lxa <= '0;
      s2_lib <= '0;
      s2_lxb <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_idx <= s1_idx;
      s2_hia <= gf4_mul(s1_ha, da) ^ s1_z[5:4];
      s2_hxa <= gf4_mul(s1_ha, db) ^ s1_z[1:0];
      s2_hib <= gf4_mul(s1_hb, db) ^ s1_z[5:4];
      s2_hxb <= gf4_mul(s1_hb, da) ^ s1_z[1:0];
      s2_lia <= gf4_mul(s1_sa, da) ^ s1_z[7:6];
      s2_lxa <= gf4_mul(s1_sa, db) ^ s1_z[3:2];
      s2_lib <= gf4_mul(s1_sb, db) ^ s1_z[7:6];
      s2_lxb <= gf4_mul(s1_sb, da) ^ s1_z[3:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A_out <= '0;
      B_out <= '0;
    end else if (s2_vld) begin
      case (s2_idx)
        2'd0: begin A_out[15:12] <= res_a; B_out[15:12] <= res_b; end
        2'd1: begin A_out[11:8]  <= res_a; B_out[11:8]  <= res_b; end
        2'd2: begin A_out[7:4]   <= res_a; B_out[7:4]   <= res_b; end
        default: begin A_out[3:0] <= res_a; B_out[3:0] <= res_b; end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_inv_sub_nibbles.sv
// Directed bench for masked_inv_sub_nibbles: latency, handshake, reset abort and full nibble-table sweep.
module tb_masked_inv_sub_nibbles;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] A_in, B_in;
  logic [11:0] Z;
  logic        rnd_req, busy, done;
  logic [15:0] A_out, B_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_inv_sub_nibbles #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .A_in(A_in), .B_in(B_in), .Z(Z),
    .rnd_req(rnd_req), .busy(busy), .done(done), .A_out(A_out), .B_out(B_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] inv_word(input logic [15:0] x);
    logic [63:0] t;
    logic [15:0] r;
    t = 64'hA59B178F6023C4DE;
    for (int p = 0; p < 4; p++) r[15-4*p -: 4] = t[63-4*int'(x[15-4*p -: 4]) -: 4];
    return r;
  endfunction

  function automatic logic [15:0] fwd_word(input logic [15:0] x);
    logic [63:0] t;
    logic [15:0] r;
    t = 64'h94ABD1856203CEF7;
    for (int p = 0; p < 4; p++) r[15-4*p -: 4] = t[63-4*int'(x[15-4*p -: 4]) -: 4];
    return r;
  endfunction

  // Starts one operation and returns in the DONE cycle (or after a 20-cycle budget).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit zzero,
                        output int lat, output int rnd);
    A_in  = a;
    B_in  = b;
    start = 1'b1;
    Z     = zzero ? 12'h000 : 12'($urandom);
    tick();
    start = 1'b0;
    lat   = 1;
    rnd   = 0;
    while (!done && lat < 20) begin
      if (rnd_req) rnd++;
      A_in = 16'($urandom);
      B_in = 16'($urandom);
      Z    = zzero ? 12'h000 : 12'($urandom);
      tick();
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, rnd, gap, ndone;
    logic [15:0] a, b, r;
    logic [7:0]  idx;

    reset = 1'b1;
    start = 1'b0;
    A_in  = '0;
    B_in  = '0;
    Z     = '0;
    repeat (2) tick();
    start = 1'b1;
    A_in  = 16'h1234;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rnd", rnd_req, 1'b0);
    check("rst_aout", A_out, 16'h0000);
    check("rst_bout", B_out, 16'h0000);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // All-zero state, zero randomness
    run_op(16'h0000, 16'h0000, 1'b1, lat, rnd);
    check("zero_lat", lat, 7);
    check("zero_xor", A_out ^ B_out, 16'hAAAA);
    check("zero_rnd", rnd, 4);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_busy_after", busy, 1'b0);

    // Example vector with fresh randomness every cycle
    run_op(16'hE2C4, 16'hF0F0, 1'b0, lat, rnd);
    check("ex_lat", lat, 7);
    check("ex_xor", A_out ^ B_out, 16'h59B1);
    check("ex_rnd", rnd, 4);
    check("ex_fwd", fwd_word(A_out ^ B_out), 16'h1234);
    tick();

    // Every (A,B) nibble pair in every position
    for (int i = 0; i < 256; i++) begin
      for (int p = 0; p < 4; p++) begin
        idx = 8'(i + 64 * p);
        a[15-4*p -: 4] = idx[7:4];
        b[15-4*p -: 4] = idx[3:0];
      end
      run_op(a, b, 1'b0, lat, rnd);
      r = A_out ^ B_out;
      check($sformatf("sweep_xor_%0d", i), r, inv_word(a ^ b));
      check($sformatf("sweep_fwd_%0d", i), fwd_word(r), a ^ b);
      tick();
    end

    // start in the second FEED cycle and in the DONE cycle is ignored
    A_in  = 16'hABCD;
    B_in  = 16'h0000;
    Z     = 12'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    A_in  = 16'h0000;
    B_in  = 16'hFFFF;
    tick();
    start = 1'b0;
    lat   = 3;
    while (!done && lat < 20) begin
      Z = 12'($urandom);
      tick();
      lat++;
    end
    check("ign_lat", lat, 7);
    check("ign_xor", A_out ^ B_out, 16'h23C4);
    start = 1'b1;
    A_in  = 16'h5555;
    tick();
    start = 1'b0;
    check("ign_done_busy", busy, 1'b0);
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      tick();
    end
    check("ign_extra_done", ndone, 0);
    check("ign_xor_hold", A_out ^ B_out, 16'h23C4);

    // Reset in the second DRAIN cycle aborts the operation
    A_in  = 16'h1111;
    B_in  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_aout", A_out, 16'h0000);
    check("abort_bout", B_out, 16'h0000);
    reset = 1'b0;
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    run_op(16'h5A5A, 16'hFFFF, 1'b0, lat, rnd);
    check("abort_new_lat", lat, 7);
    check("abort_new_xor", A_out ^ B_out, 16'h2727);
    tick();

    // Back-to-back operations
    run_op(16'h0123, 16'h0000, 1'b0, lat, rnd);
    check("b2b_first_xor", A_out ^ B_out, 16'hA59B);
    tick();
    A_in  = 16'hCDEF;
    B_in  = 16'h0000;
    Z     = 12'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    gap   = 2;
    while (!done && gap < 30) begin
      Z = 12'($urandom);
      tick();
      gap++;
    end
    check("b2b_gap", gap, 8);
    check("b2b_second_xor", A_out ^ B_out, 16'hC4DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
